bus_arbiter4: RTL and testbench

Round-robin arbiter and sequencer for the shared 16-bit 4-to-1 datapath multiplexer. It accepts up to four requesters and drives the mux select from the current grant. It registers the selected word onto the shared output with a valid strobe. A per-grant hold limit bounds how long one requester can keep the mux while others wait. It sits between requester blocks (register file ports, ALU result, immediate and memory paths) and the shared bus consumer.

---
 rtl/bus_arbiter4.sv | 160 ++++++++++++++++
 tb/tb_bus_arbiter4.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter4.sv
// bus_arbiter4: round-robin arbiter and sequencer for a shared 4-to-1 datapath mux.
//
// Grants one of four requesters at a time, drives the mux select from the grant and
// registers the selected word onto D_OUT with a VALID strobe. A per-grant hold limit
// (MAX_HOLD beats) bounds how long one owner keeps the mux while others are waiting.
//
// Ports:
//   CLK          single clock, rising edge
//   RST          asynchronous active-high reset
//   REQ[3:0]     per-requester request; REQ[i] high asks for a beat this cycle
//   D_IN0..3     requester data words
//   GNT[3:0]     one-hot grant (all zero while idle)
//   SEL[1:0]     mux select, index of the granted requester
//   D_OUT        registered transferred word
//   VALID        D_OUT was transferred on the previous edge
//   BUSY         a grant is active
module bus_arbiter4 #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [3:0]        REQ,
    input  logic [DATA_W-1:0] D_IN0,
    input  logic [DATA_W-1:0] D_IN1,
    input  logic [DATA_W-1:0] D_IN2,
    input  logic [DATA_W-1:0] D_IN3,
    output logic [3:0]        GNT,
    output logic [1:0]        SEL,
    output logic [DATA_W-1:0] D_OUT,
    output logic              VALID,
    output logic              BUSY
);

    localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_HOLD);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e            state_q, state_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        last_q, last_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] d_in [4];
    logic [3:0]        others;
    logic [3:0]        search_mask;
    logic [1:0]        winner;

    // First set bit of mask in the order last+1, last+2, last+3, last.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] mask);
        logic [1:0] idx;
        rr_pick = last;
        // Walk from the lowest priority upward so the highest-priority hit wins.
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (mask[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    always_comb begin
        d_in[0] = D_IN0;
        d_in[1] = D_IN1;
        d_in[2] = D_IN2;
        d_in[3] = D_IN3;
    end

    always_comb begin
        others      = REQ & ~(4'b0001 << sel_q);
        search_mask = (state_q == StIdle) ? REQ : others;
        winner      = rr_pick(last_q, search_mask);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = 1'b0;

        // A beat transfers regardless of what happens to the grant on this edge.
        if (state_q == StGrant && REQ[sel_q]) begin
            dout_d  = d_in[sel_q];
            valid_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (|REQ) begin
                    state_d = StGrant;
                    sel_d   = winner;
                    last_d  = winner;
                    gnt_d   = 4'b0001 << winner;
                    cnt_d   = CntOne;
                end
            end
            StGrant: begin
                if (!REQ[sel_q]) begin
                    if (|others) begin
                        sel_d  = winner;
                        last_d = winner;
                        gnt_d  = 4'b0001 << winner;
                        cnt_d  = CntOne;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = 4'b0000;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CntMax && |others) begin
                    sel_d  = winner;
                    last_d = winner;
                    gnt_d  = 4'b0001 << winner;
                    cnt_d  = CntOne;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 4'b0000;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign GNT   = gnt_q;
    assign SEL   = sel_q;
    assign D_OUT = dout_q;
    assign VALID = valid_q;
    assign BUSY  = (state_q == StGrant);

endmodule

// File: tb/tb_bus_arbiter4.sv
// Testbench for bus_arbiter4: two instances (MAX_HOLD=4 and MAX_HOLD=1) share stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_bus_arbiter4;

    logic        CLK;
    logic        RST;
    logic [3:0]  REQ;
    logic [15:0] D_IN0, D_IN1, D_IN2, D_IN3;

    logic [3:0]  gnt   [2];
    logic [1:0]  sel   [2];
    logic [15:0] dout  [2];
    logic        valid [2];
    logic        busy  [2];

    int checks   = 0;
    int failures = 0;

    // Reference model state, one per instance.
    int          hold    [2] = '{4, 1};
    int          m_owner [2];
    int          m_last  [2];
    int          m_sel   [2];
    int          m_beats [2];
    logic [15:0] m_dout  [2];
    logic        m_valid [2];

    bus_arbiter4 #(.DATA_W(16), .MAX_HOLD(4)) dut4 (
        .CLK(CLK), .RST(RST), .REQ(REQ),
        .D_IN0(D_IN0), .D_IN1(D_IN1), .D_IN2(D_IN2), .D_IN3(D_IN3),
        .GNT(gnt[0]), .SEL(sel[0]), .D_OUT(dout[0]), .VALID(valid[0]), .BUSY(busy[0])
    );

    bus_arbiter4 #(.DATA_W(16), .MAX_HOLD(1)) dut1 (
        .CLK(CLK), .RST(RST), .REQ(REQ),
        .D_IN0(D_IN0), .D_IN1(D_IN1), .D_IN2(D_IN2), .D_IN3(D_IN3),
        .GNT(gnt[1]), .SEL(sel[1]), .D_OUT(dout[1]), .VALID(valid[1]), .BUSY(busy[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Rotating priority: first requester at distance 1..4 from last.
    function automatic int rr_search(input int last, input logic [3:0] mask);
        for (int i = 1; i <= 4; i++) begin
            if (mask[(last + i) % 4]) return (last + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_last[k]  = 3;
            m_sel[k]   = 0;
            m_beats[k] = 0;
            m_dout[k]  = 16'h0;
            m_valid[k] = 1'b0;
        end
    endtask

    task automatic model_grant(input int k, input int w);
        m_owner[k] = w;
        m_last[k]  = w;
        m_sel[k]   = w;
        m_beats[k] = 0;
    endtask

    // Called right after a rising edge with the inputs that were sampled on it.
    task automatic model_update();
        logic [15:0] din [4];
        logic [3:0]  oth;
        din[0] = D_IN0; din[1] = D_IN1; din[2] = D_IN2; din[3] = D_IN3;
        for (int k = 0; k < 2; k++) begin
            if (m_owner[k] < 0) begin
                m_valid[k] = 1'b0;
                if (REQ != 4'b0) model_grant(k, rr_search(m_last[k], REQ));
            end else begin
                oth = REQ & ~(4'b0001 << m_owner[k]);
                if (REQ[m_owner[k]]) begin
                    m_dout[k]  = din[m_owner[k]];
                    m_valid[k] = 1'b1;
                    m_beats[k]++;
                    if (m_beats[k] >= hold[k] && oth != 4'b0)
                        model_grant(k, rr_search(m_last[k], oth));
                end else begin
                    m_valid[k] = 1'b0;
                    if (oth != 4'b0) model_grant(k, rr_search(m_last[k], oth));
                    else m_owner[k] = -1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("gnt%0d", k), gnt[k],
                     (m_owner[k] < 0) ? 4'b0 : (4'b0001 << m_owner[k]));
            check_eq($sformatf("sel%0d", k), sel[k], m_sel[k]);
            check_eq($sformatf("dout%0d", k), dout[k], m_dout[k]);
            check_eq($sformatf("valid%0d", k), valid[k], m_valid[k]);
            check_eq($sformatf("busy%0d", k), busy[k], (m_owner[k] >= 0));
        end
    endtask

    // Called between edges: drive, take one edge, check on the falling edge.
    task automatic step(input logic [3:0] r, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [15:0] d2, input logic [15:0] d3);
        REQ = r; D_IN0 = d0; D_IN1 = d1; D_IN2 = d2; D_IN3 = d3;
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        check_all();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    logic [3:0] r;

    initial begin
        RST = 1'b1;
        REQ = 4'b0;
        D_IN0 = 16'h0; D_IN1 = 16'h0; D_IN2 = 16'h0; D_IN3 = 16'h0;
        model_reset();
        repeat (2) @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            check_eq("rst_gnt", gnt[k], 4'b0);
            check_eq("rst_sel", sel[k], 2'd0);
            check_eq("rst_dout", dout[k], 16'h0);
            check_eq("rst_valid", valid[k], 1'b0);
            check_eq("rst_busy", busy[k], 1'b0);
        end
        RST = 1'b0;

        // Single requester keeps the grant indefinitely.
        step(4'b0001, 16'h0001, 16'h0, 16'h0, 16'h0);
        check_eq("solo_gnt", gnt[0], 4'b0001);
        step(4'b0001, 16'h0001, 16'h0, 16'h0, 16'h0);
        check_eq("solo_dout", dout[0], 16'h0001);
        check_eq("solo_valid", valid[0], 1'b1);
        repeat (12) step(4'b0001, 16'h0001, 16'h0, 16'h0, 16'h0);
        check_eq("solo_hold", gnt[0], 4'b0001);

        // Full contention: four beats per owner, VALID continuous.
        do_reset();
        for (int j = 1; j <= 17; j++) begin
            step(4'b1111, 16'h1000, 16'h2000, 16'h3000, 16'h4000);
            if (j >= 2) begin
                check_eq("rr_dout", dout[0], 16'h1000 * (((j - 2) / 4) % 4 + 1));
                check_eq("rr_valid", valid[0], 1'b1);
            end
        end
        check_eq("rr_wrap", gnt[0], 4'b0001);

        // Owner 0 releases after two beats, requester 2 takes over without a bubble.
        do_reset();
        repeat (3) step(4'b0101, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3);
        check_eq("drop_pre", gnt[0], 4'b0001);
        step(4'b0100, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3);
        check_eq("drop_gnt", gnt[0], 4'b0100);
        step(4'b0100, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3);
        check_eq("drop_dout", dout[0], 16'h00A2);

        // Fairness from IDLE with LAST=2.
        do_reset();
        step(4'b0100, 16'h0, 16'h0, 16'h0, 16'h0);
        step(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
        step(4'b1001, 16'h0B00, 16'h0, 16'h0, 16'h0B03);
        check_eq("fair_first", gnt[0], 4'b1000);
        step(4'b0001, 16'h0B00, 16'h0, 16'h0, 16'h0B03);
        check_eq("fair_next", gnt[0], 4'b0001);
        repeat (8) step(4'b1001, 16'h0B00, 16'h0, 16'h0, 16'h0B03);

        // Asynchronous reset mid-grant.
        do_reset();
        repeat (3) step(4'b1111, 16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD);
        check_eq("arst_pre", dout[0], 16'hABCD);
        #2;
        RST = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq("arst_gnt", gnt[k], 4'b0);
            check_eq("arst_valid", valid[k], 1'b0);
            check_eq("arst_dout", dout[k], 16'h0);
            check_eq("arst_busy", busy[k], 1'b0);
        end
        RST = 1'b0;
        model_reset();
        step(4'b0100, 16'h0, 16'h0, 16'h0C02, 16'h0);
        check_eq("arst_regnt", gnt[0], 4'b0100);

        // Request pulsing only between edges is ignored.
        do_reset();
        REQ = 4'b0000;
        @(posedge CLK);
        model_update();
        #2 REQ = 4'b0010;
        #2 REQ = 4'b0000;
        @(negedge CLK);
        check_all();
        check_eq("glitch_busy", busy[0], 1'b0);

        // Randomized traffic with sticky request patterns.
        r = 4'b0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            if (n % 500 == 250) do_reset();
            step(r, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
